// File: rtl/conv3_window_feeder.sv
// Streams a 3x3 kernel and an image into the conv engine as column triples, applying
// padding=1/stride=1 through two line buffers and timing valid_out to the engine pipeline.
module conv3_window_feeder #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned IMG_W      = 28,
   parameter int unsigned IMG_H      = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] pix_in,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   output logic [DATA_WIDTH-1:0] data_in0,
   output logic [DATA_WIDTH-1:0] data_in1,
   output logic [DATA_WIDTH-1:0] data_in2,
   output logic                  valid_in,
   output logic                  kernel_load,
   output logic                  valid_out,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned ColW = $clog2(IMG_W + 2);
   localparam int unsigned RowW = $clog2(IMG_H);
   localparam int unsigned AdrW = $clog2(IMG_W);
   localparam logic [ColW-1:0] ColLast     = ColW'(IMG_W + 1);
   localparam logic [ColW-1:0] ColRow0Last = ColW'(IMG_W - 1);
   localparam logic [RowW-1:0] RowLast     = RowW'(IMG_H - 1);

   typedef enum logic [2:0] {StIdle, StKernel, StRow0, StRow, StFlush, StDrain} state_e;

   state_e                state;
   logic [3:0]            kcnt;
   logic [ColW-1:0]       col;
   logic [RowW-1:0]       row;
   logic                  top_zero;
   logic [DATA_WIDTH-1:0] k0, k1;
   logic [DATA_WIDTH-1:0] top_buf [IMG_W];
   logic [DATA_WIDTH-1:0] mid_buf [IMG_W];

   // Tags riding alongside valid_in; two more stages match the engine result path.
   logic vo_tag, vo_tag_d1, last_tag, last_tag_d1;

   logic                  accept, kern_third;
   logic                  emit, emit_kern, emit_tag, emit_last;
   logic [DATA_WIDTH-1:0] e0, e1, e2, top_rd, mid_rd;
   logic [AdrW-1:0]       rd_adr, wr0_adr;

   assign busy = (state != StIdle);

   always_comb begin
      pix_ready = 1'b0;
      case (state)
         StKernel, StRow0: pix_ready = 1'b1;
         StRow:            pix_ready = (col != '0) && (col != ColLast);
         default:          pix_ready = 1'b0;
      endcase
   end

   always_comb begin
      accept     = pix_valid && pix_ready;
      kern_third = (kcnt == 4'd2) || (kcnt == 4'd5) || (kcnt == 4'd8);
      rd_adr     = AdrW'(col - ColW'(1));
      wr0_adr    = AdrW'(col);
      top_rd     = top_zero ? '0 : top_buf[rd_adr];
      mid_rd     = mid_buf[rd_adr];
   end

   // Triple to register this cycle; phase 0 and IMG_W+1 are the zero padding columns.
   always_comb begin
      emit      = 1'b0;
      emit_kern = 1'b0;
      emit_tag  = 1'b0;
      emit_last = 1'b0;
      e0        = '0;
      e1        = '0;
      e2        = '0;
      case (state)
         StKernel: begin
            if (accept && kern_third) begin
               emit      = 1'b1;
               emit_kern = 1'b1;
               e0        = k0;
               e1        = k1;
               e2        = pix_in;
            end
         end
         StRow: begin
            if (col == '0 || col == ColLast) begin
               emit     = 1'b1;
               emit_tag = (col == ColLast);
            end else if (pix_valid) begin
               emit     = 1'b1;
               emit_tag = (col >= ColW'(2));
               e0       = top_rd;
               e1       = mid_rd;
               e2       = pix_in;
            end
         end
         StFlush: begin
            emit      = 1'b1;
            emit_tag  = (col >= ColW'(2));
            emit_last = (col == ColLast);
            if (col != '0 && col != ColLast) begin
               e0 = top_rd;
               e1 = mid_rd;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         kcnt        <= '0;
         col         <= '0;
         row         <= '0;
         top_zero    <= 1'b0;
         k0          <= '0;
         k1          <= '0;
         data_in0    <= '0;
         data_in1    <= '0;
         data_in2    <= '0;
         valid_in    <= 1'b0;
         kernel_load <= 1'b0;
         vo_tag      <= 1'b0;
         vo_tag_d1   <= 1'b0;
         last_tag    <= 1'b0;
         last_tag_d1 <= 1'b0;
         valid_out   <= 1'b0;
         done        <= 1'b0;
      end else begin
         data_in0    <= e0;
         data_in1    <= e1;
         data_in2    <= e2;
         valid_in    <= emit;
         kernel_load <= emit_kern;
         vo_tag      <= emit_tag;
         last_tag    <= emit_last;
         vo_tag_d1   <= vo_tag;
         last_tag_d1 <= last_tag;
         valid_out   <= vo_tag_d1;
         done        <= last_tag_d1;
         case (state)
            StIdle: if (start) state <= StKernel;
            StKernel: begin
               if (accept) begin
                  k0 <= k1;
                  k1 <= pix_in;
                  if (kcnt == 4'd8) begin
                     kcnt  <= '0;
                     state <= StRow0;
                  end else begin
                     kcnt <= kcnt + 4'd1;
                  end
               end
            end
            StRow0: begin
               if (accept) begin
                  mid_buf[wr0_adr] <= pix_in;
                  if (col == ColRow0Last) begin
                     col      <= '0;
                     row      <= RowW'(1);
                     top_zero <= 1'b1;
                     state    <= StRow;
                  end else begin
                     col <= col + ColW'(1);
                  end
               end
            end
            StRow: begin
               if (col == ColLast) begin
                  col      <= '0;
                  top_zero <= 1'b0;
                  if (row == RowLast) begin
                     row   <= '0;
                     state <= StFlush;
                  end else begin
                     row <= row + RowW'(1);
                  end
               end else if (col == '0) begin
                  col <= ColW'(1);
               end else if (accept) begin
                  top_buf[rd_adr] <= mid_buf[rd_adr];
                  mid_buf[rd_adr] <= pix_in;
                  col             <= col + ColW'(1);
               end
            end
            StFlush: begin
               if (col == ColLast) begin
                  col   <= '0;
                  state <= StDrain;
               end else begin
                  col <= col + ColW'(1);
               end
            end
            StDrain: if (last_tag_d1) state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/conv3_window_feeder.md
Name: conv3_window_feeder

Overview:
- Upstream feeder for the 3x3 FP16 convolution engine.
- Accepts a kernel plus image pixel stream (valid/ready) and drives the engine's column-triple interface: data_in0/1/2, valid_in, kernel_load, valid_out.
- Holds two image rows in on-chip line buffers and applies padding=1 and stride=1, so the engine produces an IMG_H x IMG_W output map.
- Generates valid_out aligned to the engine's two-stage result pipeline.

Parameters:
- DATA_WIDTH, 16, FP16 word width
- IMG_W, 28, image width in pixels (>=2)
- IMG_H, 28, image height in rows (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins a kernel+image transfer; ignored unless IDLE
- pix_in  in  DATA_WIDTH  FP16 word (kernel coefficients, then pixels)
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  feeder accepts pix_in this cycle
- data_in0  out  DATA_WIDTH  top element of triple (row r-1 / kernel row 0)
- data_in1  out  DATA_WIDTH  middle element (row r / kernel row 1)
- data_in2  out  DATA_WIDTH  bottom element (row r+1 / kernel row 2)
- valid_in  out  1  triple valid, one push into engine
- kernel_load  out  1  triple is a kernel column
- valid_out  out  1  engine result valid strobe
- busy  out  1  not IDLE
- done  out  1  1-cycle pulse with the final valid_out of the image

Behaviour:
- Reset: all outputs 0; FSM to IDLE. Line buffer contents are don't-care. Reset mid-transfer aborts immediately and clears the valid_out delay line. No spurious valid_out after reset.
- Handshake: a word transfers when pix_valid && pix_ready. All data_in*, valid_in and kernel_load outputs are registered, so a triple is driven the cycle after its completing word is accepted.
- FSM states: IDLE -> KERNEL -> ROW0 -> ROW -> FLUSH -> DRAIN -> IDLE.
- IDLE: pix_ready=0. Leaves on start.
- KERNEL:
  - pix_ready=1.
  - Accepts 9 words in column-major order: K00,K10,K20,K01,...
  - Each 3rd word emits the triple (K0j,K1j,K2j) with valid_in=1 and kernel_load=1.
  - After the 9th word, go to ROW0.
- ROW0:
  - pix_ready=1.
  - Accepts IMG_W pixels of row 0 into the mid buffer; no triples emitted.
  - Sets top_zero=1; go to ROW with in_row=1.
- ROW (input row in_row, emitting output row in_row-1), phase counter c = 0..IMG_W+1:
  - c=0: pix_ready=0; emit (0,0,0).
  - c=1..IMG_W: pix_ready=1. On accept of pixel p at column c-1, emit (top[c-1] or 0 if top_zero, mid[c-1], p). Then top[c-1]<=mid[c-1] and mid[c-1]<=p. The counter stalls while pix_valid=0.
  - c=IMG_W+1: pix_ready=0; emit (0,0,0). Clear top_zero; in_row++.
  - When in_row reaches IMG_H, go to FLUSH.
- FLUSH: pix_ready=0. Emit IMG_W+2 triples back-to-back: zero, then (top[c],mid[c],0) for c=0..IMG_W-1, then zero. Go to DRAIN.
- DRAIN: wait for the delay line to empty; done=1 with the last valid_out; then IDLE.
- kernel_load=0 whenever valid_in carries image data or is low.
- valid_out timing: for every image triple with in-row index t>=2 (t counts 0..IMG_W+1 per output row), valid_out=1 exactly 2 cycles after its valid_in cycle. This matches the engine's register->result_reg->conv_reg path. Exactly IMG_H*IMG_W valid_out pulses per image.
- Counters: the kernel word counter is 0..8 and the column/row counters are sized by $clog2. All counters wrap to 0 on state exit.
- Simultaneous events: rst dominates start. start while busy is ignored. pix_valid during pix_ready=0 is not consumed (the source holds the word).

Test Plan:
1. IMG_W=4, IMG_H=3. Kernel words 1..9 with full-rate pixels 1..12 -> three kernel_load triples (1,2,3),(4,5,6),(7,8,9). First image triple is (0,0,0), then (0,1,5),(0,2,6),(0,3,7),(0,4,8),(0,0,0). Flush emits (0,0,0),(5,9,0),...,(8,12,0),(0,0,0). 12 valid_out pulses; done coincides with the 12th.
2. valid_out alignment: record valid_in cycles. Each valid_out is exactly 2 cycles after the 3rd..(W+2)th triple of each row. Zero valid_out on kernel triples.
3. Backpressure: pix_valid toggles 50% during ROW -> identical triple sequence to test 1; pix_ready low at c=0 and c=W+1 and throughout FLUSH.
4. rst asserted mid-ROW (in_row=1, c=2) -> next cycle all outputs 0 and busy=0. No valid_out follows. A subsequent start plus a full transfer reproduces test 1 (top_zero forces row -1 to zero).
5. start pulsed while busy and again with rst high -> no effect; exactly one done per accepted start.
